// File: rtl/alu_core_reg.sv
// Registered WIDTH-bit ALU: add/subtract with carry, bitwise OR/AND.
// Result and carry are captured every clock with one cycle of latency.
module alu_core_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       op_code,
    input  logic             c_in,
    output logic [WIDTH-1:0] y,
    output logic             c_out
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_OR  = 2'b10,
        OP_AND = 2'b11
    } op_e;

    op_e              w_op;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_y;
    logic             w_c;
    logic [WIDTH-1:0] r_y;
    logic             r_c;

    assign w_op = op_e'(op_code);

    // SUB reuses the adder with B inverted; c_in then acts as not-borrow-in.
    assign w_b_eff = (w_op == OP_SUB) ? ~B : B;
    assign w_sum   = {1'b0, A} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, c_in};

    always_comb begin
        w_y = '0;
        w_c = 1'b0;
        case (w_op)
            OP_ADD, OP_SUB: begin
                w_y = w_sum[WIDTH-1:0];
                w_c = w_sum[WIDTH];
            end
            OP_OR:  w_y = A | B;
            OP_AND: w_y = A & B;
            default: begin
                w_y = '0;
                w_c = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y <= '0;
            r_c <= 1'b0;
        end else begin
            r_y <= w_y;
            r_c <= w_c;
        end
    end

    assign y     = r_y;
    assign c_out = r_c;

endmodule

// File: tb/tb_alu_core_reg.sv
// Scoreboard bench for alu_core_reg: stimulus pushes expected results,
// a monitor pops and compares one result per rising edge.
module tb_alu_core_reg;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] y;
        logic         c;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [1:0]   op_code;
    logic         c_in;
    logic [W-1:0] y;
    logic         c_out;

    exp_t q[$];
    int   checks;
    int   fails;

    alu_core_reg #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .op_code (op_code),
        .c_in    (c_in),
        .y       (y),
        .c_out   (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the operation rules.
    function automatic exp_t model(input int a, input int b, input int op, input int ci);
        exp_t e;
        int   mask;
        int   r;
        mask = (1 << W) - 1;
        e.c  = 1'b0;
        case (op)
            0: begin
                r   = a + b + ci;
                e.y = W'(r & mask);
                e.c = (r > mask);
            end
            1: begin
                r   = a - b - (ci ? 0 : 1);
                e.y = W'(r & mask);
                e.c = (r >= 0);
            end
            2: e.y = W'(a | b);
            default: e.y = W'(a & b);
        endcase
        return e;
    endfunction

    task automatic check(input string name, input logic [W-1:0] gy, input logic gc,
                         input logic [W-1:0] ey, input logic ec);
        checks++;
        if (gy !== ey || gc !== ec) begin
            fails++;
            $display("FAIL %s: got y=%h c_out=%b, expected y=%h c_out=%b",
                     name, gy, gc, ey, ec);
        end
    endtask

    task automatic set_inputs(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [1:0] op, input logic ci);
        A = a; B = b; op_code = op; c_in = ci;
    endtask

    // Drive on the falling edge; expectation taken from fixed values.
    task automatic drive_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [1:0] op, input logic ci,
                             input logic [W-1:0] ey, input logic ec);
        exp_t e;
        @(negedge clk);
        set_inputs(a, b, op, ci);
        e.y = ey;
        e.c = ec;
        q.push_back(e);
    endtask

    task automatic drive_rand();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
        logic         ci;
        a  = W'($urandom);
        b  = W'($urandom);
        op = 2'($urandom);
        ci = 1'($urandom);
        @(negedge clk);
        set_inputs(a, b, op, ci);
        q.push_back(model(int'(a), int'(b), int'(op), int'(ci)));
    endtask

    // Monitor: every rising edge out of reset presents one result.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            check("pipeline", y, c_out, e.y, e.c);
        end
    end

    initial begin
        checks = 0;
        fails  = 0;
        rst_n  = 1'b0;
        set_inputs(8'hFF, 8'hFF, 2'b00, 1'b1);

        // Outputs stay clear across clock edges while in reset.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", y, c_out, '0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        q.push_back('{y: 8'hFF, c: 1'b1});

        drive_exp(8'hFC, 8'h65, 2'b00, 1'b1, 8'h62, 1'b1);
        drive_exp(8'hFC, 8'h65, 2'b01, 1'b1, 8'h97, 1'b1);
        drive_exp(8'hFC, 8'h65, 2'b10, 1'b1, 8'hFD, 1'b0);
        drive_exp(8'hFC, 8'h65, 2'b11, 1'b1, 8'h64, 1'b0);
        drive_exp(8'hFC, 8'h65, 2'b00, 1'b0, 8'h61, 1'b1);
        drive_exp(8'hFC, 8'h65, 2'b01, 1'b0, 8'h96, 1'b1);
        drive_exp(8'hFC, 8'h65, 2'b10, 1'b0, 8'hFD, 1'b0);
        drive_exp(8'hFC, 8'h65, 2'b11, 1'b0, 8'h64, 1'b0);
        drive_exp(8'hFF, 8'h00, 2'b00, 1'b1, 8'h00, 1'b1);
        drive_exp(8'h00, 8'h01, 2'b01, 1'b1, 8'hFF, 1'b0);
        drive_exp(8'h00, 8'h00, 2'b01, 1'b0, 8'hFF, 1'b0);
        drive_exp(8'h7F, 8'h7F, 2'b01, 1'b1, 8'h00, 1'b1);

        for (int i = 0; i < 150; i++) drive_rand();

        // Mid-stream reset: clear immediately and drop the in-flight result.
        drive_exp(8'hFF, 8'hFF, 2'b00, 1'b1, 8'hFF, 1'b1);
        @(posedge clk);
        drive_rand();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", y, c_out, '0, 1'b0);
        q.delete();
        @(posedge clk);
        #1;
        check("reset_mid", y, c_out, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 100; i++) drive_rand();

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL drain: %0d results outstanding, expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
